// File: rtl/gyro_bias_cal.sv
// Gyro bias calibration: averages 2^CAL_SHIFT at-rest samples per axis, then
// emits bias-subtracted, saturated, dead-banded rates.
module gyro_bias_cal #(
  parameter int          CAL_SHIFT = 8,
  parameter logic [15:0] DEADBAND  = 16'd4
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic        raw_valid_in,
  input  logic [15:0] raw_gx_in,
  input  logic [15:0] raw_gy_in,
  input  logic [15:0] raw_gz_in,
  input  logic        recal_in,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        valid_out,
  output logic        calibrated,
  output logic [15:0] bias_x,
  output logic [15:0] bias_y,
  output logic [15:0] bias_z
);

  localparam int ACC_W = 16 + CAL_SHIFT;
  localparam int CNT_W = CAL_SHIFT + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CAL_SHIFT) - 1);

  typedef enum logic {CAL, RUN} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc_x, acc_y, acc_z;
  logic signed [ACC_W-1:0] sum_x, sum_y, sum_z;
  logic [CNT_W-1:0]        cnt;
  logic                    accept_cal, accept_run, cal_done;

  function automatic logic signed [ACC_W-1:0] sext_acc(input logic [15:0] v);
    return {{CAL_SHIFT{v[15]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)
      return 16'sh7fff;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Magnitude is taken at 17 bits so that -32768 does not wrap.
  function automatic logic signed [15:0] dead_band(input logic signed [15:0] v);
    logic [16:0] mag;
    mag = v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
    if (mag <= {1'b0, DEADBAND})
      return '0;
    else
      return v;
  endfunction

  function automatic logic signed [15:0] correct(input logic [15:0] raw,
                                                 input logic [15:0] bias);
    logic signed [16:0] diff;
    diff = $signed({raw[15], raw}) - $signed({bias[15], bias});
    return dead_band(sat16(diff));
  endfunction

  always_comb begin
    accept_cal = (state == CAL) && raw_valid_in && !recal_in;
    accept_run = (state == RUN) && raw_valid_in && !recal_in;
    cal_done   = accept_cal && (cnt == CNT_LAST);
    sum_x      = acc_x + sext_acc(raw_gx_in);
    sum_y      = acc_y + sext_acc(raw_gy_in);
    sum_z      = acc_z + sext_acc(raw_gz_in);
    state_nxt  = state;
    if (recal_in)
      state_nxt = CAL;
    else if (cal_done)
      state_nxt = RUN;
  end

  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in)
      state <= CAL;
    else
      state <= state_nxt;
  end

  assign calibrated = (state == RUN);

  // Calibration stage: accumulate, then latch bias as the floored mean.
  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      acc_x  <= '0;
      acc_y  <= '0;
      acc_z  <= '0;
      cnt    <= '0;
      bias_x <= '0;
      bias_y <= '0;
      bias_z <= '0;
    end else if (recal_in) begin
      acc_x <= '0;
      acc_y <= '0;
      acc_z <= '0;
      cnt   <= '0;
    end else if (accept_cal) begin
      acc_x <= sum_x;
      acc_y <= sum_y;
      acc_z <= sum_z;
      cnt   <= cnt + 1'b1;
      if (cal_done) begin
        bias_x <= sum_x[CAL_SHIFT +: 16];
        bias_y <= sum_y[CAL_SHIFT +: 16];
        bias_z <= sum_z[CAL_SHIFT +: 16];
      end
    end
  end

  // Output stage: corrected rates registered with a one-cycle valid pulse.
  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      gx        <= '0;
      gy        <= '0;
      gz        <= '0;
      valid_out <= 1'b0;
    end else if (recal_in) begin
      gx        <= '0;
      gy        <= '0;
      gz        <= '0;
      valid_out <= 1'b0;
    end else if (accept_run) begin
      gx        <= correct(raw_gx_in, bias_x);
      gy        <= correct(raw_gy_in, bias_y);
      gz        <= correct(raw_gz_in, bias_z);
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule
